// File: rtl/ks_step0_pkg.sv
// Shared definitions for the Kogge-Stone adder pipeline stages:
// default operand width and the sign / effective-operation encodings.
package ks_step0_pkg;

    localparam int KS_WIDTH = 25;

    typedef enum logic {
        KS_SIGN_POS = 1'b0,
        KS_SIGN_NEG = 1'b1
    } ks_sign_e;

    typedef enum logic {
        KS_OP_ADD = 1'b0,
        KS_OP_SUB = 1'b1
    } ks_eff_op_e;

    // Carry-in for the adder: subtraction is A + ~B + 1.
    function automatic logic ks_cin(input logic eff_sub);
        return eff_sub == KS_OP_SUB;
    endfunction

endpackage

// File: rtl/ks_step0_if.sv
// Stream interface of the KS step-0 stage: an operand-pair input channel
// and a G0/P0 output channel.
// Handshake: a channel transfers exactly when its valid and ready are both 1
// at a rising clock edge; the producer holds valid and data until then.
interface ks_step0_if import ks_step0_pkg::*; #(
    parameter int WIDTH = KS_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_eff_sub;
    logic             in_sign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_G0;
    logic [WIDTH-1:0] out_P0;
    logic             out_sign;

    // Upstream/downstream environment side.
    modport master (
        output in_valid, in_a, in_b, in_eff_sub, in_sign, out_ready,
        input  in_ready, out_valid, out_G0, out_P0, out_sign
    );

    // The pipeline stage itself.
    modport slave (
        input  in_valid, in_a, in_b, in_eff_sub, in_sign, out_ready,
        output in_ready, out_valid, out_G0, out_P0, out_sign
    );
endinterface

// File: rtl/ks_pg_cell.sv
// Per-bit generate/propagate cell. The cin input lets bit 0 absorb the
// adder carry-in so the prefix tree needs no separate carry path; upper
// bits tie cin to 0 and reduce to plain a&b / a^b.
module ks_pg_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic g,
    output logic p
);
    logic half_p;

    assign half_p = a ^ b;
    assign g      = (a & b) | (half_p & cin);
    assign p      = half_p ^ cin;
endmodule

// File: rtl/ks_step0.sv
// KS step 0: forms bitwise G0/P0 from aligned mantissas (carry-in folded
// into bit 0) and registers them behind a 2-entry main + skid buffer so
// in_ready is a flop with no path from out_ready.
module ks_step0 import ks_step0_pkg::*; #(
    parameter int WIDTH = KS_WIDTH
) (
    input  logic         clock,
    input  logic         resetn,
    ks_step0_if.slave    bus
);
    logic [WIDTH-1:0] b_x;
    logic             cin;
    logic [WIDTH-1:0] pg_g;
    logic [WIDTH-1:0] pg_p;

    logic             accept;
    logic             drain;

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_g_q, main_g_d;
    logic [WIDTH-1:0] main_p_q, main_p_d;
    logic             main_sign_q, main_sign_d;
    logic             skid_full_q, skid_full_d;
    logic [WIDTH-1:0] skid_g_q, skid_g_d;
    logic [WIDTH-1:0] skid_p_q, skid_p_d;
    logic             skid_sign_q, skid_sign_d;
    logic             in_ready_q, in_ready_d;

    // Operand B conditioning: invert for subtraction, carry-in goes to bit 0.
    always_comb begin
        b_x = (bus.in_eff_sub == KS_OP_SUB) ? ~bus.in_b : bus.in_b;
        cin = ks_cin(bus.in_eff_sub);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == 0) begin : g_lsb
            ks_pg_cell u_cell (
                .a   (bus.in_a[i]),
                .b   (b_x[i]),
                .cin (cin),
                .g   (pg_g[i]),
                .p   (pg_p[i])
            );
        end else begin : g_upper
            ks_pg_cell u_cell (
                .a   (bus.in_a[i]),
                .b   (b_x[i]),
                .cin (1'b0),
                .g   (pg_g[i]),
                .p   (pg_p[i])
            );
        end
    end

    // Buffer control: fill main first, overflow into skid, refill main from skid.
    always_comb begin
        accept       = bus.in_valid & in_ready_q;
        drain        = main_valid_q & bus.out_ready;
        main_valid_d = main_valid_q;
        main_g_d     = main_g_q;
        main_p_d     = main_p_q;
        main_sign_d  = main_sign_q;
        skid_full_d  = skid_full_q;
        skid_g_d     = skid_g_q;
        skid_p_d     = skid_p_q;
        skid_sign_d  = skid_sign_q;

        if (skid_full_q) begin
            // in_ready is low here, so nothing new can arrive this cycle.
            if (drain) begin
                main_g_d    = skid_g_q;
                main_p_d    = skid_p_q;
                main_sign_d = skid_sign_q;
                skid_full_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || drain) begin
                main_valid_d = 1'b1;
                main_g_d     = pg_g;
                main_p_d     = pg_p;
                main_sign_d  = bus.in_sign;
            end else begin
                skid_full_d  = 1'b1;
                skid_g_d     = pg_g;
                skid_p_d     = pg_p;
                skid_sign_d  = bus.in_sign;
            end
        end else if (drain) begin
            main_valid_d = 1'b0;
        end

        in_ready_d = !skid_full_d;
    end

    // State registers; reset empties both entries and clears the data.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            main_valid_q <= 1'b0;
            main_g_q     <= '0;
            main_p_q     <= '0;
            main_sign_q  <= 1'b0;
            skid_full_q  <= 1'b0;
            skid_g_q     <= '0;
            skid_p_q     <= '0;
            skid_sign_q  <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_g_q     <= main_g_d;
            main_p_q     <= main_p_d;
            main_sign_q  <= main_sign_d;
            skid_full_q  <= skid_full_d;
            skid_g_q     <= skid_g_d;
            skid_p_q     <= skid_p_d;
            skid_sign_q  <= skid_sign_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid_q;
    assign bus.out_G0    = main_g_q;
    assign bus.out_P0    = main_p_q;
    assign bus.out_sign  = main_sign_q;

endmodule

// File: tb/tb_ks_step0.sv
// Bench for ks_step0: directed add/subtract vectors, back-pressure,
// streaming, random stalls and mid-operation reset against a per-bit
// arithmetic reference and a FIFO scoreboard.
module tb_ks_step0;
    import ks_step0_pkg::*;

    localparam int W = KS_WIDTH;
    typedef logic [2*W:0] item_t;   // {sign, G0, P0}

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    ks_step0_if #(.WIDTH(W)) bus ();

    ks_step0 #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    item_t exp_q[$];

    // Reference: each bit column is a tiny addition a_i + bx_i (+ cin at bit 0);
    // generate = column carries out, propagate = column sum bit.
    function automatic item_t ref_item(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub, input logic sign);
        logic [W-1:0] bx;
        logic [W-1:0] g;
        logic [W-1:0] p;
        int           t;
        bx = sub ? ~b : b;
        for (int i = 0; i < W; i++) begin
            t    = int'(a[i]) + int'(bx[i]) + ((i == 0) ? int'(sub) : 0);
            g[i] = (t >= 2);
            p[i] = ((t % 2) == 1);
        end
        return {sign, g, p};
    endfunction

    // What the remaining prefix stages will produce from G0/P0: {carry_out, sum}.
    function automatic logic [W:0] prefix_sum(input logic [W-1:0] g, input logic [W-1:0] p);
        logic [W-1:0] s;
        logic         c;
        s[0] = p[0];
        c    = g[0];
        for (int i = 1; i < W; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        return {c, s};
    endfunction

    function automatic logic [W:0] ref_total(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub);
        logic [W-1:0] bx;
        bx = sub ? ~b : b;
        return {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic sign);
        bus.in_valid   = v;
        bus.in_a       = a;
        bus.in_b       = b;
        bus.in_eff_sub = sub;
        bus.in_sign    = sign;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        resetn = 1'b0;
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_G0 !== '0) begin failures++; $display("FAIL reset_G0: got %h expected 0", bus.out_G0); end
        checks++; if (bus.out_P0 !== '0) begin failures++; $display("FAIL reset_P0: got %h expected 0", bus.out_P0); end
        checks++; if (bus.out_sign !== 1'b0) begin failures++; $display("FAIL reset_sign: got %b expected 0", bus.out_sign); end
        cycle();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_held_in_ready: got %b expected 0", bus.in_ready); end
        @(negedge clock);
        resetn = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL release_before_edge_in_ready: got %b expected 0", bus.in_ready); end
        cycle();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL release_after_edge_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_add();
        bus.out_ready = 1'b1;
        drive(1'b1, 25'h0000003, 25'h0000001, 1'b0, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_G0 !== 25'h0000001) begin failures++; $display("FAIL add_G0: got %h expected 0000001", bus.out_G0); end
        checks++; if (bus.out_P0 !== 25'h0000002) begin failures++; $display("FAIL add_P0: got %h expected 0000002", bus.out_P0); end
        checks++; if (bus.out_sign !== 1'b1) begin failures++; $display("FAIL add_sign: got %b expected 1", bus.out_sign); end
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_drained: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_subtract();
        logic [W:0] total;
        bus.out_ready = 1'b1;
        drive(1'b1, 25'h0000003, 25'h0000001, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        total = prefix_sum(bus.out_G0, bus.out_P0);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL sub_out_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_G0 !== 25'h0000003) begin failures++; $display("FAIL sub_G0: got %h expected 0000003", bus.out_G0); end
        checks++; if (bus.out_P0 !== 25'h1FFFFFC) begin failures++; $display("FAIL sub_P0: got %h expected 1fffffc", bus.out_P0); end
        checks++; if (bus.out_sign !== 1'b0) begin failures++; $display("FAIL sub_sign: got %b expected 0", bus.out_sign); end
        checks++; if (total !== {1'b1, 25'h0000002}) begin failures++; $display("FAIL sub_prefix_sum: got %h expected 2000002", total); end
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a[3];
        logic [W-1:0] b[3];
        logic         s[3];
        logic         sg[3];
        item_t        e[3];
        item_t        cur;
        for (int i = 0; i < 3; i++) begin
            a[i]  = W'($urandom);
            b[i]  = W'($urandom);
            s[i]  = 1'($urandom_range(0, 1));
            sg[i] = 1'($urandom_range(0, 1));
            e[i]  = ref_item(a[i], b[i], s[i], sg[i]);
        end
        bus.out_ready = 1'b0;
        drive(1'b1, a[0], b[0], s[0], sg[0]);
        cycle();
        cur = {bus.out_sign, bus.out_G0, bus.out_P0};
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_1: got %b expected 1", bus.in_ready); end
        checks++; if (cur !== e[0]) begin failures++; $display("FAIL bp_item1: got %h expected %h", cur, e[0]); end
        drive(1'b1, a[1], b[1], s[1], sg[1]);
        cycle();
        drive(1'b1, a[2], b[2], s[2], sg[2]);
        for (int k = 0; k < 3; k++) begin
            cur = {bus.out_sign, bus.out_G0, bus.out_P0};
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low[%0d]: got %b expected 0", k, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold[%0d]: got %b expected 1", k, bus.out_valid); end
            checks++; if (cur !== e[0]) begin failures++; $display("FAIL bp_hold_item1[%0d]: got %h expected %h", k, cur, e[0]); end
            if (k < 2) cycle();
        end
        bus.out_ready = 1'b1;
        cycle();
        cur = {bus.out_sign, bus.out_G0, bus.out_P0};
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_item2: got %b expected 1", bus.out_valid); end
        checks++; if (cur !== e[1]) begin failures++; $display("FAIL bp_item2: got %h expected %h", cur, e[1]); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_rise: got %b expected 1", bus.in_ready); end
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cur = {bus.out_sign, bus.out_G0, bus.out_P0};
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_item3: got %b expected 1", bus.out_valid); end
        checks++; if (cur !== e[2]) begin failures++; $display("FAIL bp_item3: got %h expected %h", cur, e[2]); end
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_streaming();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic         sg;
        item_t        e;
        item_t        cur;
        logic [W:0]   total;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            s  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            e  = ref_item(a, b, s, sg);
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", n, bus.in_ready); end
            drive(1'b1, a, b, s, sg);
            cycle();
            cur   = {bus.out_sign, bus.out_G0, bus.out_P0};
            total = prefix_sum(bus.out_G0, bus.out_P0);
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d]: got %b expected 1", n, bus.out_valid); end
            checks++; if (cur !== e) begin failures++; $display("FAIL stream_item[%0d]: got %h expected %h", n, cur, e); end
            checks++; if (total !== ref_total(a, b, s)) begin failures++; $display("FAIL stream_sum[%0d]: got %h expected %h", n, total, ref_total(a, b, s)); end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_drained: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_random_stall();
        localparam int N_ITEMS = 1000;
        localparam int BUDGET  = 20000;
        int    sent = 0;
        int    recv = 0;
        int    cyc  = 0;
        logic  acc;
        logic  drn;
        logic  stalled_prev = 1'b0;
        item_t held = '0;
        item_t cur;
        item_t pend = '0;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic         sg;
        exp_q.delete();
        while (recv < N_ITEMS && cyc < BUDGET) begin
            cur = {bus.out_sign, bus.out_G0, bus.out_P0};
            checks++; if (bus.out_valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL stall_out_valid@%0d: got %b expected %b", cyc, bus.out_valid, exp_q.size() != 0); end
            checks++; if (bus.in_ready !== (exp_q.size() < 2)) begin failures++; $display("FAIL stall_in_ready@%0d: got %b expected %b", cyc, bus.in_ready, exp_q.size() < 2); end
            if (stalled_prev) begin
                checks++; if (cur !== held) begin failures++; $display("FAIL stall_stable@%0d: got %h expected %h", cyc, cur, held); end
            end
            if (bus.out_valid && exp_q.size() > 0) begin
                checks++; if (cur !== exp_q[0]) begin failures++; $display("FAIL stall_order@%0d: got %h expected %h", cyc, cur, exp_q[0]); end
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            if (sent < N_ITEMS && $urandom_range(0, 9) < 7) begin
                a  = W'($urandom);
                b  = W'($urandom);
                s  = 1'($urandom_range(0, 1));
                sg = 1'($urandom_range(0, 1));
                drive(1'b1, a, b, s, sg);
                pend = ref_item(a, b, s, sg);
            end else begin
                drive(1'b0, '0, '0, 1'b0, 1'b0);
            end
            acc          = bus.in_valid && bus.in_ready;
            drn          = bus.out_valid && bus.out_ready;
            stalled_prev = bus.out_valid && !bus.out_ready;
            held         = cur;
            cycle();
            cyc++;
            if (drn) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                recv++;
            end
            if (acc) begin
                exp_q.push_back(pend);
                sent++;
            end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++; if (recv !== N_ITEMS) begin failures++; $display("FAIL stall_received: got %0d expected %0d (budget %0d cycles)", recv, N_ITEMS, BUDGET); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL stall_leftover: got %0d expected 0", exp_q.size()); end
        bus.out_ready = 1'b1;
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_drained: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1);
        cycle();
        drive(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_full_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_full_valid: got %b expected 1", bus.out_valid); end
        #3;
        resetn = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_G0 !== '0) begin failures++; $display("FAIL mid_reset_G0: got %h expected 0", bus.out_G0); end
        checks++; if (bus.out_P0 !== '0) begin failures++; $display("FAIL mid_reset_P0: got %h expected 0", bus.out_P0); end
        checks++; if (bus.out_sign !== 1'b0) begin failures++; $display("FAIL mid_reset_sign: got %b expected 0", bus.out_sign); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_in_ready: got %b expected 0", bus.in_ready); end
        exp_q.delete();
        @(negedge clock);
        resetn = 1'b1;
        cycle();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_release_in_ready: got %b expected 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_no_stale[%0d]: got %b expected 0", k, bus.out_valid); end
            cycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_subtract();
        test_back_to_back();
        test_streaming();
        test_random_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
